// File: rtl/seq_num_pkg.sv
// Shared types, status encoding and ring-age helper for the sequence-number allocator.
package seq_num_pkg;

  localparam int unsigned SEQ_NUM_W_MAX = 16;

  typedef logic [SEQ_NUM_W_MAX-1:0] seq_num_t;

  localparam logic ALLOC = 1'b1;
  localparam logic FREE  = 1'b0;

  // Ages are distances from tail, taken modulo 2^bits so one helper serves any ring size.
  function automatic logic seq_is_older(input seq_num_t a, input seq_num_t b,
                                        input seq_num_t tail, input int unsigned bits);
    seq_num_t mask;
    mask = seq_num_t'((32'd1 << bits) - 32'd1);
    return ((a - tail) & mask) < ((b - tail) & mask);
  endfunction

endpackage

// File: rtl/seq_num_reclaim.sv
// Tail reclaim scan: counts the leading run of FREE entries at the tail, bounded by the
// number of entries in flight.
module seq_num_reclaim
  import seq_num_pkg::*;
#(
  parameter int unsigned p_seq_num_bits  = 5,
  parameter int unsigned p_reclaim_width = 2
) (
  input  logic [p_reclaim_width-1:0] win_status,
  input  logic [p_seq_num_bits-1:0]  num_in_flight,
  output logic [p_seq_num_bits-1:0]  tail_inc
);

  typedef logic [p_seq_num_bits-1:0] seq_t;

  logic [p_reclaim_width-1:0] in_window;

  genvar gi;
  generate
    for (gi = 0; gi < p_reclaim_width; gi++) begin : g_window
      assign in_window[gi] = (seq_t'(gi) < num_in_flight);
    end
  endgenerate

  always_comb begin
    logic run;
    run      = 1'b1;
    tail_inc = '0;
    for (int j = 0; j < p_reclaim_width; j++) begin
      run      = run && (win_status[j] == FREE) && in_window[j];
      tail_inc = tail_inc + seq_t'(run);
    end
  end

endmodule

// File: rtl/seq_num_gen_l4.sv
// Superscalar sequence-number allocator: multi-slot allocate, multi-port commit, squash
// rewind with same-cycle bypass, and in-order tail reclaim.
module seq_num_gen_l4
  import seq_num_pkg::*;
#(
  parameter int unsigned p_seq_num_bits  = 5,
  parameter int unsigned p_alloc_width   = 2,
  parameter int unsigned p_commit_width  = 2,
  parameter int unsigned p_reclaim_width = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [p_seq_num_bits-1:0] alloc_seq_num [p_alloc_width],
  output logic [p_alloc_width-1:0]  alloc_val,
  input  logic [p_alloc_width-1:0]  alloc_rdy,
  input  logic [p_commit_width-1:0] commit_val,
  input  logic [p_seq_num_bits-1:0] commit_seq_num [p_commit_width],
  input  logic                      squash_val,
  input  logic [p_seq_num_bits-1:0] squash_seq_num,
  output logic [p_seq_num_bits-1:0] num_in_flight,
  output logic                      empty
);

  localparam int unsigned NUM_ENTRIES = 1 << p_seq_num_bits;

  typedef logic [p_seq_num_bits-1:0] seq_t;

  seq_t                       head_q, head_d;
  seq_t                       tail_q, tail_d;
  logic [NUM_ENTRIES-1:0]     status_q, status_d;
  seq_t                       base;
  seq_t                       avail;
  seq_t                       fire_cnt;
  seq_t                       tail_inc;
  logic                       squash_all;
  logic [p_alloc_width-1:0]   fire;
  logic [p_reclaim_width-1:0] win_status;

  // A squash rewinds the allocation point in the same cycle it is presented.
  assign base       = squash_val ? squash_seq_num + seq_t'(1) : head_q;
  assign avail      = seq_t'(NUM_ENTRIES - 1) - (base - tail_q);
  assign squash_all = (squash_seq_num == tail_q - seq_t'(1));

  genvar gi;
  generate
    for (gi = 0; gi < p_alloc_width; gi++) begin : g_slot
      assign alloc_seq_num[gi] = base + seq_t'(gi);
      assign alloc_val[gi]     = (seq_t'(gi) < avail);
    end
    for (gi = 0; gi < p_reclaim_width; gi++) begin : g_win
      assign win_status[gi] = status_q[tail_q + seq_t'(gi)];
    end
  endgenerate

  // Only a contiguous prefix of ready slots fires.
  always_comb begin
    logic run;
    run      = 1'b1;
    fire     = '0;
    fire_cnt = '0;
    for (int k = 0; k < p_alloc_width; k++) begin
      run      = run && alloc_val[k] && alloc_rdy[k];
      fire[k]  = run;
      fire_cnt = fire_cnt + seq_t'(run);
    end
  end

  seq_num_reclaim #(
    .p_seq_num_bits  (p_seq_num_bits),
    .p_reclaim_width (p_reclaim_width)
  ) u_reclaim (
    .win_status    (win_status),
    .num_in_flight (num_in_flight),
    .tail_inc      (tail_inc)
  );

  // Later writes take priority: squash clear, then commit clear, then allocation set.
  always_comb begin
    status_d = status_q;
    if (squash_val) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (squash_all || seq_is_older(seq_num_t'(squash_seq_num), seq_num_t'(i),
                                       seq_num_t'(tail_q), p_seq_num_bits)) begin
          status_d[i] = FREE;
        end
      end
    end
    for (int p = 0; p < p_commit_width; p++) begin
      if (commit_val[p]) status_d[commit_seq_num[p]] = FREE;
    end
    for (int k = 0; k < p_alloc_width; k++) begin
      if (fire[k]) status_d[alloc_seq_num[k]] = ALLOC;
    end
  end

  always_comb begin
    head_d = base + fire_cnt;
    tail_d = tail_q + tail_inc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      status_q <= {NUM_ENTRIES{FREE}};
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      status_q <= status_d;
    end
  end

  assign num_in_flight = head_q - tail_q;
  assign empty         = (num_in_flight == '0);

`ifndef SYNTHESIS
  function automatic string trace();
    return $sformatf("head=%0d tail=%0d in_flight=%0d status=%b",
                     head_q, tail_q, num_in_flight, status_q);
  endfunction
`endif

endmodule

// File: tb/tb_seq_num_gen_l4.sv
// Bench for seq_num_gen_l4: directed scenarios with literal expectations, then randomized
// legal traffic checked every cycle against a ring model held in plain integers.
module tb_seq_num_gen_l4;

  localparam int N  = 4;
  localparam int AW = 2;
  localparam int CW = 2;
  localparam int RW = 2;
  localparam int NE = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  alloc_seq_num [AW];
  logic [AW-1:0] alloc_val;
  logic [AW-1:0] alloc_rdy;
  logic [CW-1:0] commit_val;
  logic [N-1:0]  commit_seq_num [CW];
  logic          squash_val;
  logic [N-1:0]  squash_seq_num;
  logic [N-1:0]  num_in_flight;
  logic          empty;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_num_gen_l4 #(
    .p_seq_num_bits  (N),
    .p_alloc_width   (AW),
    .p_commit_width  (CW),
    .p_reclaim_width (RW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_seq_num  (alloc_seq_num),
    .alloc_val      (alloc_val),
    .alloc_rdy      (alloc_rdy),
    .commit_val     (commit_val),
    .commit_seq_num (commit_seq_num),
    .squash_val     (squash_val),
    .squash_seq_num (squash_seq_num),
    .num_in_flight  (num_in_flight),
    .empty          (empty)
  );

  // ---------------- reference model ----------------
  int m_head = 0;
  int m_tail = 0;
  bit m_alloc [NE];
  bit m_ok = 0;

  function automatic int wrap(input int x);
    return ((x % NE) + NE) % NE;
  endfunction

  function automatic int m_base();
    return squash_val ? wrap(int'(squash_seq_num) + 1) : m_head;
  endfunction

  function automatic int m_avail();
    return (NE - 1) - wrap(m_base() - m_tail);
  endfunction

  function automatic int m_nfire();
    int n;
    n = 0;
    for (int k = 0; k < AW; k++) begin
      if (k < m_avail() && alloc_rdy[k]) n++;
      else break;
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin : model
    int base, nf, nif, rec, surv;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_head = 0;
        m_tail = 0;
        for (int i = 0; i < NE; i++) m_alloc[i] = 1'b0;
        m_ok = 1;
      end else if (m_ok) begin
        base = m_base();
        nf   = m_nfire();
        nif  = wrap(m_head - m_tail);
        rec  = 0;
        while (rec < RW && rec < nif && !m_alloc[wrap(m_tail + rec)]) rec++;
        if (squash_val) begin
          surv = wrap(int'(squash_seq_num) + 1 - m_tail);
          for (int d = surv; d < nif; d++) m_alloc[wrap(m_tail + d)] = 1'b0;
        end
        for (int p = 0; p < CW; p++)
          if (commit_val[p]) m_alloc[commit_seq_num[p]] = 1'b0;
        for (int k = 0; k < nf; k++) m_alloc[wrap(base + k)] = 1'b1;
        m_head = wrap(base + nf);
        m_tail = wrap(m_tail + rec);
      end
    end
  end

  initial begin : compare
    int base, avail;
    logic [AW-1:0] ev;
    forever begin
      @(negedge clk);
      if (m_ok) begin
        base  = m_base();
        avail = m_avail();
        for (int k = 0; k < AW; k++) ev[k] = (k < avail);
        chk("model_alloc_val", 32'(alloc_val), 32'(ev));
        for (int k = 0; k < AW; k++)
          chk($sformatf("model_alloc_seq_num%0d", k), 32'(alloc_seq_num[k]), 32'(wrap(base + k)));
        chk("model_num_in_flight", 32'(num_in_flight), 32'(wrap(m_head - m_tail)));
        chk("model_empty", 32'(empty), 32'(m_head == m_tail));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    alloc_rdy  = '0;
    commit_val = '0;
    squash_val = 1'b0;
    squash_seq_num = '0;
    for (int p = 0; p < CW; p++) commit_seq_num[p] = '0;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic commit2(input int a, input int b);
    commit_val        = 2'b11;
    commit_seq_num[0] = N'(a);
    commit_seq_num[1] = N'(b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin : main
    int nif, idx, cand[$];
    rst = 1'b1;
    alloc_rdy = '0; commit_val = '0; squash_val = 1'b0; squash_seq_num = '0;
    for (int p = 0; p < CW; p++) commit_seq_num[p] = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    at_neg();
    chk("reset_alloc_val", 32'(alloc_val), 32'd3);
    chk("reset_seq0", 32'(alloc_seq_num[0]), 32'd0);
    chk("reset_seq1", 32'(alloc_seq_num[1]), 32'd1);
    chk("reset_in_flight", 32'(num_in_flight), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);
    tick();

    // Dual allocation, then gap and single-slot cases
    repeat (3) begin alloc_rdy = 2'b11; tick(); end
    at_neg();
    chk("alloc3_in_flight", 32'(num_in_flight), 32'd6);
    chk("alloc3_seq0", 32'(alloc_seq_num[0]), 32'd6);
    alloc_rdy = 2'b10;
    tick();
    at_neg();
    chk("gap_no_alloc", 32'(num_in_flight), 32'd6);
    alloc_rdy = 2'b01;
    tick();
    at_neg();
    chk("slot0_only", 32'(num_in_flight), 32'd7);

    // Two commits in one cycle, then an out-of-order hole
    commit2(1, 0);
    tick();
    at_neg();
    chk("commit_lat1", 32'(num_in_flight), 32'd7);
    tick();
    at_neg();
    chk("commit_lat2", 32'(num_in_flight), 32'd5);
    commit_val = 2'b01; commit_seq_num[0] = 4'd3;
    tick(); tick(); tick();
    at_neg();
    chk("hole_blocks_tail", 32'(num_in_flight), 32'd5);
    commit_val = 2'b01; commit_seq_num[0] = 4'd2;
    tick(); tick();
    at_neg();
    chk("hole_filled", 32'(num_in_flight), 32'd3);

    // Fill to capacity
    repeat (5) begin alloc_rdy = 2'b11; tick(); end
    alloc_rdy = 2'b01;
    tick();
    at_neg();
    chk("fill14_val", 32'(alloc_val), 32'd1);
    alloc_rdy = 2'b01;
    tick();
    at_neg();
    chk("fill15_val", 32'(alloc_val), 32'd0);
    chk("fill15_in_flight", 32'(num_in_flight), 32'd15);
    commit_val = 2'b01; commit_seq_num[0] = 4'd4;
    tick();
    at_neg();
    chk("full_commit_lat1", 32'(alloc_val), 32'd0);
    tick();
    at_neg();
    chk("full_commit_lat2", 32'(alloc_val), 32'd1);

    // Mid-operation reset, then squash bypass with allocation
    do_reset();
    at_neg();
    chk("rst_mid_in_flight", 32'(num_in_flight), 32'd0);
    chk("rst_mid_empty", 32'(empty), 32'd1);
    repeat (5) begin alloc_rdy = 2'b11; tick(); end
    squash_val = 1'b1; squash_seq_num = 4'd3; alloc_rdy = 2'b11;
    at_neg();
    chk("squash_bypass_seq0", 32'(alloc_seq_num[0]), 32'd4);
    chk("squash_bypass_seq1", 32'(alloc_seq_num[1]), 32'd5);
    chk("squash_bypass_val", 32'(alloc_val), 32'd3);
    tick();
    at_neg();
    chk("squash_in_flight", 32'(num_in_flight), 32'd6);

    // Wrap case: tail=14, head=3
    do_reset();
    repeat (7) begin alloc_rdy = 2'b11; tick(); end
    for (int i = 0; i < 7; i++) begin commit2(2 * i, 2 * i + 1); tick(); end
    tick(); tick(); tick();
    at_neg();
    chk("drain_in_flight", 32'(num_in_flight), 32'd0);
    repeat (2) begin alloc_rdy = 2'b11; tick(); end
    alloc_rdy = 2'b01;
    tick();
    at_neg();
    chk("wrap_in_flight", 32'(num_in_flight), 32'd5);
    squash_val = 1'b1; squash_seq_num = 4'd15;
    tick();
    at_neg();
    chk("wrap_squash_in_flight", 32'(num_in_flight), 32'd2);
    chk("wrap_squash_head", 32'(alloc_seq_num[0]), 32'd0);
    commit2(14, 15);
    tick(); tick();
    at_neg();
    chk("wrap_drain_in_flight", 32'(num_in_flight), 32'd0);
    chk("wrap_drain_empty", 32'(empty), 32'd1);
    tick();

    // Randomized legal traffic
    repeat (3000) begin
      rst       = ($urandom_range(0, 299) == 0);
      alloc_rdy = AW'($urandom);
      nif       = wrap(m_head - m_tail);
      cand.delete();
      for (int d = 0; d < nif; d++)
        if (m_alloc[wrap(m_tail + d)]) cand.push_back(wrap(m_tail + d));
      for (int p = 0; p < CW; p++) begin
        if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
          idx = int'($urandom_range(0, cand.size() - 1));
          commit_val[p]     = 1'b1;
          commit_seq_num[p] = N'(cand[idx]);
          cand.delete(idx);
        end
      end
      if ($urandom_range(0, 7) == 0) begin
        squash_val     = 1'b1;
        squash_seq_num = N'(wrap(m_tail - 1 + int'($urandom_range(0, nif))));
      end
      tick();
    end
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
